instr_encoder: RTL and testbench

- Inverse of the core's instruction-type decode: takes a decoded request and produces the 32-bit RV64I instruction word.
- Request fields: instruction class (same 4-bit class code the main decoder produces), register indices, funct fields and a signed immediate.
- Encoded words pass through an output FIFO with valid/ready handshakes on both sides.
- Used by the boot/self-test loader to write programs into instruction memory, and by the verification environment as the golden encoder.

---
 rtl/instr_encoder.sv | 193 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: builds 32-bit RV64I instruction words from decoded requests
// and queues them in a small output FIFO.
//
// Ports:
//   i_clk, i_arstn        clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready = FIFO not full)
//   i_type                instruction class code (0..10 legal)
//   i_rd/i_rs1/i_rs2      register indices
//   i_funct3/i_funct7     funct fields
//   i_imm                 signed immediate (full value for U types)
//   o_instr_valid/i_instr_ready  output handshake on the FIFO head
//   o_instr, o_illegal    head word and its illegal-request flag
//   o_count               FIFO occupancy
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_arstn,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [3:0]                    i_type,
    input  logic [4:0]                    i_rd,
    input  logic [4:0]                    i_rs1,
    input  logic [4:0]                    i_rs2,
    input  logic [2:0]                    i_funct3,
    input  logic [6:0]                    i_funct7,
    input  logic [31:0]                   i_imm,
    output logic                          o_instr_valid,
    input  logic                          i_instr_ready,
    output logic [31:0]                   o_instr,
    output logic                          o_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [3:0] {
        CL_I_LOAD  = 4'd0,
        CL_I_ALU   = 4'd1,
        CL_I_JALR  = 4'd2,
        CL_I_ALUW  = 4'd3,
        CL_S       = 4'd4,
        CL_R       = 4'd5,
        CL_R_W     = 4'd6,
        CL_B       = 4'd7,
        CL_J       = 4'd8,
        CL_U_AUIPC = 4'd9,
        CL_U_LUI   = 4'd10
    } instr_class_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ALUW  = 7'b0011011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // ---------------------------------------------------------------
    // Combinational encoder
    // ---------------------------------------------------------------
    instr_class_e       w_class;
    logic signed [31:0] w_imm_s;
    logic               w_shift;
    logic               w_fit12;
    logic               w_fit_b;
    logic               w_fit_j;
    logic [31:0]        w_word;
    logic               w_illegal;

    assign w_class = instr_class_e'(i_type);
    assign w_imm_s = i_imm;
    assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_fit12 = (w_imm_s >= -2048) && (w_imm_s <= 2047);
    assign w_fit_b = !i_imm[0] && (w_imm_s >= -4096) && (w_imm_s <= 4094);
    assign w_fit_j = !i_imm[0] && (w_imm_s >= -1048576) && (w_imm_s <= 1048574);

    always_comb begin
        w_word    = '0;
        w_illegal = 1'b0;
        case (w_class)
            CL_I_LOAD: begin
                w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
                w_illegal = !w_fit12;
            end
            CL_I_ALU: begin
                if (w_shift) begin
                    // RV64 shamt is 6 bits, so funct7[0] is overlaid by shamt[5]
                    w_word    = {i_funct7[6:1], i_imm[5:0], i_rs1, i_funct3, i_rd, OP_ALU};
                    w_illegal = (w_imm_s < 0) || (w_imm_s > 63);
                end else begin
                    w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_ALU};
                    w_illegal = !w_fit12;
                end
            end
            CL_I_JALR: begin
                w_word    = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
                w_illegal = !w_fit12;
            end
            CL_I_ALUW: begin
                if (w_shift) begin
                    w_word    = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_ALUW};
                    w_illegal = (w_imm_s < 0) || (w_imm_s > 31);
                end else begin
                    w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_ALUW};
                    w_illegal = !w_fit12;
                end
            end
            CL_S: begin
                w_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
                w_illegal = !w_fit12;
            end
            CL_R: w_word   = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            CL_R_W: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_RW};
            CL_B: begin
                w_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_B};
                w_illegal = !w_fit_b;
            end
            CL_J: begin
                w_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_J};
                w_illegal = !w_fit_j;
            end
            CL_U_AUIPC: begin
                w_word    = {i_imm[31:12], i_rd, OP_AUIPC};
                w_illegal = (i_imm[11:0] != 12'd0);
            end
            CL_U_LUI: begin
                w_word    = {i_imm[31:12], i_rd, OP_LUI};
                w_illegal = (i_imm[11:0] != 12'd0);
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_word = NOP_WORD;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------
    logic [31:0]   r_mem_instr [FIFO_DEPTH];
    logic          r_mem_ill   [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_req_ready   = (r_count < CW'(FIFO_DEPTH));
    assign o_instr_valid = (r_count != '0);
    assign w_push        = i_req_valid && o_req_ready;
    assign w_pop         = o_instr_valid && i_instr_ready;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_ill[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_word;
                r_mem_ill[r_wr_ptr]   <= w_illegal;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty FIFO presents zeros rather than a stale entry.
    assign o_instr   = o_instr_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_illegal = o_instr_valid ? r_mem_ill[r_rd_ptr] : 1'b0;
    assign o_count   = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model with a
// per-cycle compare, directed literal vectors, backpressure, wrap and reset.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        i_clk;
    logic        i_arstn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [3:0]  i_type;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_imm;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic        o_illegal;
    logic [2:0]  o_count;

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_arstn      (i_arstn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_type       (i_type),
        .i_rd         (i_rd),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_funct3     (i_funct3),
        .i_funct7     (i_funct7),
        .i_imm        (i_imm),
        .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .o_instr      (o_instr),
        .o_illegal    (o_illegal),
        .o_count      (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        bit        ill;
        bit [31:0] w;
    } enc_t;

    bit [6:0] OPC [11] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h33,
                           7'h3B, 7'h63, 7'h6F, 7'h17, 7'h37};

    int   checks   = 0;
    int   failures = 0;
    bit   rand_en  = 1'b0;
    enc_t q[$];

    function automatic req_t mk(input int t, input int rd, input int rs1, input int rs2,
                                input int f3, input int f7, input logic [31:0] imm);
        req_t r;
        r.t = 4'(t); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = imm;
        return r;
    endfunction

    // Reference encoder: field placement by shift-and-mask from the ISA layout.
    function automatic enc_t model_encode(input req_t r);
        enc_t      e;
        bit [31:0] u, rd, rs1, rs2, f3, f7, op, w;
        longint    v;
        bit        ok, sh;
        u = r.imm; v = longint'($signed(r.imm));
        rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        f3 = 32'(r.f3); f7 = 32'(r.f7);
        sh = (r.f3 == 3'd1) || (r.f3 == 3'd5);
        ok = 1'b1; w = 32'h0;
        if (r.t > 4'd10) begin
            e.ill = 1'b1; e.w = 32'h13;
            return e;
        end
        op = 32'(OPC[r.t]);
        case (r.t)
            4'd0, 4'd2: begin
                if (r.t == 4'd2) f3 = 32'h0;
                ok = (v >= -2048) && (v <= 2047);
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            4'd1, 4'd3: begin
                if (sh && r.t == 4'd1) begin
                    ok = (v >= 0) && (v <= 63);
                    w = ((f7 >> 1) << 26) | ((u & 32'd63) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                end else if (sh) begin
                    ok = (v >= 0) && (v <= 31);
                    w = (f7 << 25) | ((u & 32'd31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                end else begin
                    ok = (v >= -2048) && (v <= 2047);
                    w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                end
            end
            4'd4: begin
                ok = (v >= -2048) && (v <= 2047);
                w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 32'h1F) << 7) | op;
            end
            4'd5, 4'd6: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            4'd7: begin
                ok = ((u & 32'h1) == 0) && (v >= -4096) && (v <= 4094);
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                  | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | op;
            end
            4'd8: begin
                ok = ((u & 32'h1) == 0) && (v >= -1048576) && (v <= 1048574);
                w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
                  | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            end
            default: begin
                ok = ((u & 32'hFFF) == 0);
                w = (u & 32'hFFFFF000) | (rd << 7) | op;
            end
        endcase
        e.ill = !ok;
        e.w   = ok ? w : 32'h13;
        return e;
    endfunction

    // Model state follows the handshake rules: accept when fewer than DEPTH held.
    always @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            q.delete();
        end else begin
            bit push, pop;
            req_t r;
            push = i_req_valid && (q.size() < DEPTH);
            pop  = (q.size() > 0) && i_instr_ready;
            r = mk(int'(i_type), int'(i_rd), int'(i_rs1), int'(i_rs2),
                   int'(i_funct3), int'(i_funct7), i_imm);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(model_encode(r));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_compare();
        check("count", 32'(o_count), 32'(q.size()));
        check("instr_valid", 32'(o_instr_valid), 32'(q.size() > 0));
        check("req_ready", 32'(o_req_ready), 32'(q.size() < DEPTH));
        if (q.size() > 0) begin
            check("instr", o_instr, q[0].w);
            check("illegal", 32'(o_illegal), 32'(q[0].ill));
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        model_compare();
    endtask

    task automatic drive(input req_t r);
        i_type = r.t; i_rd = r.rd; i_rs1 = r.rs1; i_rs2 = r.rs2;
        i_funct3 = r.f3; i_funct7 = r.f7; i_imm = r.imm;
    endtask

    task automatic send(input req_t r);
        bit acc;
        int n;
        drive(r);
        i_req_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            if (rand_en) i_instr_ready = 1'($urandom_range(0, 1));
            acc = o_req_ready;
            tick();
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout at %0t: got no accept expected accept within 50 cycles", $time);
        end
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        repeat (n) begin
            if (rand_en) i_instr_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic directed(input string name, input req_t r, input logic [31:0] w, input bit ill);
        i_instr_ready = 1'b0;
        send(r);
        i_req_valid = 1'b0;
        check({name, "_valid"}, 32'(o_instr_valid), 32'd1);
        check({name, "_word"}, o_instr, w);
        check({name, "_ill"}, 32'(o_illegal), 32'(ill));
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;
    endtask

    function automatic req_t gen_req();
        req_t r;
        r.t   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        r.f3  = 3'($urandom); r.f7  = 7'($urandom);
        case ($urandom_range(0, 4))
            0: r.imm = 32'($urandom_range(0, 70));
            1: r.imm = 32'($urandom_range(0, 8200)) - 32'd4100;
            2: r.imm = $urandom();
            3: r.imm = $urandom() & 32'hFFFFF000;
            default: r.imm = 32'($urandom_range(0, 2097160)) - 32'd1048580;
        endcase
        return r;
    endfunction

    initial begin
        enc_t e;
        i_arstn = 1'b0; i_req_valid = 1'b0; i_instr_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0));

        // Reference model pinned against hand-encoded words.
        e = model_encode(mk(1, 1, 0, 0, 0, 0, 32'd5));        check("model_addi", e.w, 32'h00500093);
        e = model_encode(mk(4, 0, 3, 2, 2, 0, 32'd8));        check("model_sw", e.w, 32'h0021A423);
        e = model_encode(mk(8, 1, 0, 0, 0, 0, 32'd8));        check("model_jal", e.w, 32'h008000EF);
        e = model_encode(mk(10, 5, 0, 0, 0, 0, 32'h12345000)); check("model_lui", e.w, 32'h123452B7);
        e = model_encode(mk(7, 0, 1, 2, 0, 0, 32'd3));        check("model_beq_odd", 32'(e.ill), 32'd1);
        e = model_encode(mk(1, 1, 0, 0, 0, 0, 32'd2048));     check("model_addi_big", 32'(e.ill), 32'd1);
        e = model_encode(mk(15, 1, 0, 0, 0, 0, 32'd0));       check("model_bad_type", e.w, 32'h00000013);

        repeat (2) @(negedge i_clk);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_illegal", 32'(o_illegal), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        i_arstn = 1'b1;
        tick();

        directed("addi", mk(1, 1, 0, 0, 0, 0, 32'd5), 32'h00500093, 1'b0);
        directed("sw", mk(4, 0, 3, 2, 2, 0, 32'd8), 32'h0021A423, 1'b0);
        directed("jal", mk(8, 1, 0, 0, 0, 0, 32'd8), 32'h008000EF, 1'b0);
        directed("lui", mk(10, 5, 0, 0, 0, 0, 32'h12345000), 32'h123452B7, 1'b0);
        directed("beq_odd", mk(7, 0, 1, 2, 0, 0, 32'd3), 32'h00000013, 1'b1);
        directed("addi_2048", mk(1, 1, 0, 0, 0, 0, 32'd2048), 32'h00000013, 1'b1);
        directed("type_f", mk(15, 1, 2, 3, 0, 0, 32'd0), 32'h00000013, 1'b1);
        directed("srai_63", mk(1, 2, 3, 0, 5, 7'h20, 32'd63), 32'h43F1D113, 1'b0);
        directed("slliw_32", mk(3, 2, 3, 0, 1, 0, 32'd32), 32'h00000013, 1'b1);
        directed("beq_min", mk(7, 0, 1, 2, 0, 0, 32'hFFFFF000), 32'h80208063, 1'b0);

        // Backpressure: four accepted, fifth held until the first pop.
        i_instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(gen_req());
        check("bp_ready_low", 32'(o_req_ready), 32'd0);
        check("bp_count_full", 32'(o_count), 32'd4);
        drive(gen_req());
        i_req_valid = 1'b1;
        tick(); tick();
        check("bp_held_count", 32'(o_count), 32'd4);
        i_instr_ready = 1'b1;
        tick();
        check("bp_ready_back", 32'(o_req_ready), 32'd1);
        check("bp_count_3", 32'(o_count), 32'd3);
        tick();
        check("bp_pushpop", 32'(o_count), 32'd3);
        idle(5);

        // Full-rate push and pop across pointer wrap.
        i_instr_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send(gen_req());
            check("stream_count", 32'(o_count), 32'd1);
        end
        idle(3);

        // Randomized traffic with random consumer stalls.
        rand_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) send(gen_req());
            else idle(1);
        end
        rand_en = 1'b0;
        i_instr_ready = 1'b1;
        idle(6);

        // Reset with entries queued and a request in flight.
        i_instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(gen_req());
        drive(gen_req());
        i_req_valid = 1'b1;
        #2 i_arstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_instr_valid), 32'd0);
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_ready", 32'(o_req_ready), 32'd1);
        check("mid_rst_instr", o_instr, 32'd0);
        i_req_valid = 1'b0;
        tick();
        #2 i_arstn = 1'b1;
        tick();
        directed("post_rst_addi", mk(1, 1, 0, 0, 0, 0, 32'd5), 32'h00500093, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
